// File: rtl/segre_pkg.sv
// Shared types for the segre core: memory access size, plus the memory
// arbiter's FSM state and access owner.
package segre_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ACCESS = 2'b01,
    ARB_RESP   = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/segre_mem_arbiter_if.sv
// Bundle of the fetch, load-store and memory-pin signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core's.
interface segre_mem_arbiter_if
  import segre_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
) ();

  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_flush_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [WORD_WIDTH-1:0] if_rdata_o;

  logic                  lsu_req_i;
  logic                  lsu_we_i;
  logic [ADDR_WIDTH-1:0] lsu_addr_i;
  logic [WORD_WIDTH-1:0] lsu_wdata_i;
  memop_data_type_e      lsu_type_i;
  logic                  lsu_gnt_o;
  logic                  lsu_rvalid_o;
  logic [WORD_WIDTH-1:0] lsu_rdata_o;

  logic [WORD_WIDTH-1:0] mem_rd_data_i;
  logic [WORD_WIDTH-1:0] mem_wr_data_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic                  mem_rd_o;
  logic                  mem_wr_o;
  memop_data_type_e      mem_data_type_o;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_type_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_rd_data_i,
    output mem_wr_data_o, addr_o, mem_rd_o, mem_wr_o, mem_data_type_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_type_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_rd_data_i,
    input  mem_wr_data_o, addr_o, mem_rd_o, mem_wr_o, mem_data_type_o
  );

endinterface

// File: rtl/segre_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the LSU: one
// fixed-latency access in flight, LSU priority, starvation-bounded fetch.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int WORD_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk_i,
  input logic             rsn_i,
  segre_mem_arbiter_if.slave bus
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] STARVE_LIM_C = CNT_W'(STARVE_LIMIT);
  localparam logic [3:0]       LAT_C        = 4'(MEM_LATENCY);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  memop_data_type_e      type_q, type_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic [3:0]            lat_q, lat_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  flush_q, flush_d;

  logic lsu_wins;
  logic if_gnt, lsu_gnt;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    type_d   = type_q;
    rdata_d  = rdata_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    flush_d  = flush_q;
    if_gnt   = 1'b0;
    lsu_gnt  = 1'b0;
    lsu_wins = bus.lsu_req_i && !(bus.if_req_i && (starve_q >= STARVE_LIM_C));

    case (state_q)
      ARB_IDLE: begin
        flush_d = 1'b0;
        if (lsu_wins) begin
          lsu_gnt = 1'b1;
          owner_d = OWNER_LSU;
          we_d    = bus.lsu_we_i;
          addr_d  = bus.lsu_addr_i;
          wdata_d = bus.lsu_wdata_i;
          type_d  = bus.lsu_type_i;
          lat_d   = LAT_C;
          state_d = ARB_ACCESS;
          // A fetch that lost this arbitration moves one step closer to being forced through.
          if (bus.if_req_i) begin
            starve_d = (starve_q == '1) ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end else if (bus.if_req_i) begin
          if_gnt   = 1'b1;
          owner_d  = OWNER_IF;
          we_d     = 1'b0;
          addr_d   = bus.if_addr_i;
          wdata_d  = '0;
          type_d   = WORD;
          lat_d    = LAT_C;
          state_d  = ARB_ACCESS;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      ARB_ACCESS: begin
        if (bus.if_flush_i && (owner_q == OWNER_IF)) begin
          flush_d = 1'b1;
        end
        if (lat_q == 4'd1) begin
          rdata_d = bus.mem_rd_data_i;
          state_d = ARB_RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        flush_d = 1'b0;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWNER_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      type_q   <= WORD;
      rdata_q  <= '0;
      lat_q    <= '0;
      starve_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      type_q   <= type_d;
      rdata_q  <= rdata_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      flush_q  <= flush_d;
    end
  end

  assign bus.if_gnt_o        = if_gnt;
  assign bus.lsu_gnt_o       = lsu_gnt;
  assign bus.addr_o          = addr_q;
  assign bus.mem_wr_data_o   = wdata_q;
  assign bus.mem_data_type_o = type_q;
  assign bus.mem_rd_o        = (state_q == ARB_ACCESS) && !we_q;
  assign bus.mem_wr_o        = (state_q == ARB_ACCESS) && we_q;
  assign bus.if_rdata_o      = rdata_q;
  assign bus.lsu_rdata_o     = rdata_q;

  // A flush arriving in the response cycle itself still discards that response.
  assign bus.if_rvalid_o  = (state_q == ARB_RESP) && (owner_q == OWNER_IF) &&
                            !flush_q && !bus.if_flush_i;
  assign bus.lsu_rvalid_o = (state_q == ARB_RESP) && (owner_q == OWNER_LSU);

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Randomized scoreboard bench for segre_mem_arbiter against a transaction-level
// model of arbitration, latency, starvation and flush.
module tb_segre_mem_arbiter;
  import segre_pkg::*;

  localparam int AW   = 32;
  localparam int WW   = 32;
  localparam int LAT  = 2;
  localparam int SLIM = 4;

  typedef struct {
    logic        is_if;
    logic        is_store;
    logic [31:0] data;
    logic        flushed;
  } exp_t;

  logic clk_i = 1'b0;
  logic rsn_i;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  segre_mem_arbiter_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  segre_mem_arbiter #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)
  ) dut (
    .clk_i(clk_i),
    .rsn_i(rsn_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0101_0013;
  endfunction

  // Behavioural memory behind the arbiter's pins, 16 words aliased by addr[5:2].
  logic [WW-1:0] mem [16];
  bit            mem_ready;
  always @(posedge clk_i) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_wr_o) begin
      mem[bus.addr_o[5:2]] <= bus.mem_wr_data_o;
    end
  end
  always_comb bus.mem_rd_data_i = mem[bus.addr_o[5:2]];

  // Reference model state: memory image, busy countdown, fetch losses, current access.
  logic [31:0]      ref_mem [16];
  int               free_in;
  int               losses;
  logic             cur_if, cur_we, cur_flushed;
  logic [31:0]      cur_addr, cur_wdata;
  memop_data_type_e cur_type;
  logic             if_pend, lsu_pend, lsu_we, do_flush;
  logic [31:0]      if_a, lsu_a, lsu_wd;
  memop_data_type_e lsu_ty;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bus();
    bus.if_req_i    = if_pend;
    bus.if_addr_i   = if_a;
    bus.if_flush_i  = do_flush;
    bus.lsu_req_i   = lsu_pend;
    bus.lsu_we_i    = lsu_we;
    bus.lsu_addr_i  = lsu_a;
    bus.lsu_wdata_i = lsu_wd;
    bus.lsu_type_i  = lsu_ty;
  endtask

  task automatic model_reset();
    free_in = 0; losses = 0; cur_if = 1'b0; cur_we = 1'b0; cur_flushed = 1'b0;
    cur_addr = '0; cur_wdata = '0; cur_type = WORD;
    if_pend = 1'b0; lsu_pend = 1'b0; lsu_we = 1'b0; do_flush = 1'b0;
    if_a = '0; lsu_a = '0; lsu_wd = '0; lsu_ty = WORD;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_if_gnt"},     bus.if_gnt_o,        0);
    check_output({tag, "_lsu_gnt"},    bus.lsu_gnt_o,       0);
    check_output({tag, "_if_rvalid"},  bus.if_rvalid_o,     0);
    check_output({tag, "_lsu_rvalid"}, bus.lsu_rvalid_o,    0);
    check_output({tag, "_mem_rd"},     bus.mem_rd_o,        0);
    check_output({tag, "_mem_wr"},     bus.mem_wr_o,        0);
    check_output({tag, "_addr"},       bus.addr_o,          0);
    check_output({tag, "_wdata"},      bus.mem_wr_data_o,   0);
    check_output({tag, "_type"},       bus.mem_data_type_o, WORD);
  endtask

  // Compares the cycle's grants, strobes and rvalids with the model, then advances it.
  task automatic sample_cycle();
    logic exp_lsu, exp_if, in_access, resp;
    exp_t e;
    exp_lsu   = (free_in == 0) && lsu_pend && !(if_pend && losses >= SLIM);
    exp_if    = (free_in == 0) && if_pend && !exp_lsu;
    in_access = (free_in >= 2) && (free_in <= LAT + 1);
    resp      = (free_in == 1);
    check_output("if_gnt",  bus.if_gnt_o,  exp_if);
    check_output("lsu_gnt", bus.lsu_gnt_o, exp_lsu);
    check_output("mem_rd",  bus.mem_rd_o,  in_access && !cur_we);
    check_output("mem_wr",  bus.mem_wr_o,  in_access && cur_we);
    if (in_access) begin
      check_output("addr", bus.addr_o, cur_addr);
      check_output("type", bus.mem_data_type_o, cur_type);
      if (cur_we) check_output("wdata", bus.mem_wr_data_o, cur_wdata);
    end
    check_output("if_rvalid",  bus.if_rvalid_o,  resp && cur_if && !cur_flushed);
    check_output("lsu_rvalid", bus.lsu_rvalid_o, resp && !cur_if);

    if (exp_lsu) begin
      losses      = if_pend ? ((losses < 255) ? losses + 1 : losses) : 0;
      e.is_if     = 1'b0;
      e.is_store  = lsu_we;
      e.data      = lsu_we ? 32'h0 : ref_mem[lsu_a[5:2]];
      e.flushed   = 1'b0;
      if (lsu_we) ref_mem[lsu_a[5:2]] = lsu_wd;
      sb_q.push_back(e);
      cur_if = 1'b0; cur_we = lsu_we; cur_addr = lsu_a; cur_wdata = lsu_wd; cur_type = lsu_ty;
      cur_flushed = 1'b0; lsu_pend = 1'b0; free_in = LAT + 2;
    end else if (exp_if) begin
      losses     = 0;
      e.is_if    = 1'b1;
      e.is_store = 1'b0;
      e.data     = ref_mem[if_a[5:2]];
      e.flushed  = 1'b0;
      sb_q.push_back(e);
      cur_if = 1'b1; cur_we = 1'b0; cur_addr = if_a; cur_type = WORD;
      cur_flushed = 1'b0; if_pend = 1'b0; free_in = LAT + 2;
    end else if (free_in == 0 && !if_pend) begin
      losses = 0;
    end

    if (do_flush && cur_if && in_access) begin
      cur_flushed = 1'b1;
      sb_q[sb_q.size()-1].flushed = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input int n_cycles, input int pct_if, input int pct_lsu);
    int off;
    logic [31:0] idx;
    for (int c = 0; c < n_cycles; c++) begin
      @(negedge clk_i);
      if (free_in > 0) free_in--;
      if (!if_pend && $urandom_range(0, 99) < pct_if) begin
        if_pend = 1'b1;
        if_a    = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      end else if (if_pend && free_in > 0 && pct_if < 100 && $urandom_range(0, 99) < 5) begin
        if_pend = 1'b0;
      end
      if (!lsu_pend && $urandom_range(0, 99) < pct_lsu) begin
        lsu_pend = 1'b1;
        lsu_we   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0:       begin lsu_ty = BYTE; off = $urandom_range(0, 3);     end
          1:       begin lsu_ty = HALF; off = 2 * $urandom_range(0, 1); end
          default: begin lsu_ty = WORD; off = 0;                        end
        endcase
        idx    = 32'($urandom_range(0, 15));
        lsu_a  = 32'h200 + idx * 4 + 32'(off);
        lsu_wd = $urandom;
      end
      if (cur_if && !cur_flushed && free_in >= 2 && free_in <= LAT + 1)
        do_flush = ($urandom_range(0, 99) < 20);
      else if (!(cur_if && free_in >= 1))
        do_flush = ($urandom_range(0, 99) < 5);
      else
        do_flush = 1'b0;
      drive_bus();
      #1;
      sample_cycle();
    end
  endtask

  // Scoreboard monitor: pops the oldest live expectation on every response pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (bus.if_rvalid_o && bus.lsu_rvalid_o)
        check_output("rvalid_exclusive", 32'd1, 32'd0);
      if (bus.if_rvalid_o || bus.lsu_rvalid_o) begin
        while (sb_q.size() > 0 && sb_q[0].flushed) void'(sb_q.pop_front());
        if (sb_q.size() == 0) begin
          check_output("sb_unexpected_rvalid", {bus.if_rvalid_o, bus.lsu_rvalid_o}, 0);
        end else begin
          e = sb_q.pop_front();
          check_output("sb_owner", {30'b0, bus.if_rvalid_o, bus.lsu_rvalid_o},
                       e.is_if ? 32'd2 : 32'd1);
          if (!e.is_store)
            check_output("sb_rdata", e.is_if ? bus.if_rdata_o : bus.lsu_rdata_o, e.data);
        end
      end
    end
  end

  initial begin
    int live;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    model_reset();
    drive_bus();
    rsn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check_reset_values("rst");
    check_output("rst_if_rdata",  bus.if_rdata_o,  0);
    check_output("rst_lsu_rdata", bus.lsu_rdata_o, 0);
    rsn_i = 1'b1;

    apply_stimulus(400, 40, 55);
    apply_stimulus(60, 100, 100);
    apply_stimulus(30, 0, 0);

    // Store interrupted by reset one cycle after its grant.
    @(negedge clk_i);
    lsu_pend = 1'b1; lsu_we = 1'b1; lsu_a = 32'h204; lsu_wd = 32'hDEAD_BEEF; lsu_ty = WORD;
    drive_bus();
    #1;
    check_output("rstmid_gnt", bus.lsu_gnt_o, 1);
    @(negedge clk_i);
    lsu_pend = 1'b0;
    drive_bus();
    #1;
    check_output("rstmid_wr_t1", bus.mem_wr_o, 1);
    rsn_i = 1'b0;
    ref_mem[1] = 32'hDEAD_BEEF;
    @(negedge clk_i);
    #1;
    check_reset_values("rstmid_t2");
    rsn_i = 1'b1;
    @(negedge clk_i);
    #1;
    check_output("rstmid_no_ack", bus.lsu_rvalid_o, 0);
    model_reset();

    apply_stimulus(200, 40, 55);
    apply_stimulus(30, 0, 0);

    live = 0;
    foreach (sb_q[i]) if (!sb_q[i].flushed) live++;
    check_output("sb_drained", 32'(live), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
